// File: rtl/axi_read_arbiter.sv
// Two-port round-robin arbiter sharing one AXI read channel (AR + R).
// One burst is outstanding at a time. The R path is combinational.
// Port rlast is generated from a local beat count.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_p0_req,
    input  logic                  i_p1_req,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [7:0]            i_p0_len,
    input  logic [7:0]            i_p1_len,
    output logic                  o_p0_gnt,
    output logic                  o_p1_gnt,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,
    output logic                  o_p0_rvalid,
    output logic                  o_p1_rvalid,
    output logic                  o_p0_rlast,
    output logic                  o_p1_rlast,
    input  logic                  i_p0_rready,
    input  logic                  i_p1_rready,
    output logic [ADDR_WIDTH-1:0] o_m_araddr,
    output logic [7:0]            o_m_arlen,
    output logic                  o_m_arvalid,
    input  logic                  i_m_arready,
    input  logic [DATA_WIDTH-1:0] i_m_rdata,
    input  logic                  i_m_rvalid,
    input  logic                  i_m_rlast,
    output logic                  o_m_rready,
    output logic                  o_busy,
    output logic                  o_owner,
    output logic                  o_len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_arvalid;
    logic                  r_owner;
    logic                  r_last_gnt;
    logic                  r_p0_gnt, r_p1_gnt;
    logic [7:0]            r_beat_cnt;
    logic                  r_len_err;

    logic w_any_req, w_sel, w_cnt_last, w_beat, w_end;
    logic w_m_rready, w_p0_rvalid, w_p1_rvalid;

    // On a tie, pick the port that was not served last.
    assign w_any_req  = i_p0_req | i_p1_req;
    assign w_sel      = (i_p0_req & i_p1_req) ? ~r_last_gnt : i_p1_req;
    assign w_cnt_last = (r_beat_cnt == r_arlen);
    assign w_beat     = i_m_rvalid & w_m_rready;
    assign w_end      = w_cnt_last | i_m_rlast;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and R-path steering toward the owning port.
    always_comb begin
        w_next      = r_state;
        w_m_rready  = 1'b0;
        w_p0_rvalid = 1'b0;
        w_p1_rvalid = 1'b0;
        case (r_state)
            IDLE: if (w_any_req) w_next = ADDR;
            ADDR: if (i_m_arready) w_next = DATA;
            DATA: begin
                w_m_rready  = r_owner ? i_p1_rready : i_p0_rready;
                w_p0_rvalid = i_m_rvalid & ~r_owner;
                w_p1_rvalid = i_m_rvalid &  r_owner;
                if (i_m_rvalid && w_m_rready && w_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Burst registers: latch the request, run the AR handshake, count beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_p0_gnt   <= 1'b0;
            r_p1_gnt   <= 1'b0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_p0_gnt <= 1'b0;
            r_p1_gnt <= 1'b0;
            case (r_state)
                IDLE: if (w_any_req) begin
                    r_araddr  <= w_sel ? i_p1_addr : i_p0_addr;
                    r_arlen   <= w_sel ? i_p1_len  : i_p0_len;
                    r_owner   <= w_sel;
                    r_arvalid <= 1'b1;
                end
                ADDR: if (i_m_arready) begin
                    r_arvalid  <= 1'b0;
                    r_p0_gnt   <= ~r_owner;
                    r_p1_gnt   <= r_owner;
                    r_beat_cnt <= '0;
                end
                DATA: if (w_beat) begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                    if (w_end) begin
                        r_last_gnt <= r_owner;
                        if (i_m_rlast != w_cnt_last) r_len_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_p0_gnt    = r_p0_gnt;
    assign o_p1_gnt    = r_p1_gnt;
    assign o_p0_rdata  = i_m_rdata;
    assign o_p1_rdata  = i_m_rdata;
    assign o_p0_rvalid = w_p0_rvalid;
    assign o_p1_rvalid = w_p1_rvalid;
    assign o_p0_rlast  = w_p0_rvalid & w_cnt_last;
    assign o_p1_rlast  = w_p1_rvalid & w_cnt_last;
    assign o_m_araddr  = r_araddr;
    assign o_m_arlen   = r_arlen;
    assign o_m_arvalid = r_arvalid;
    assign o_m_rready  = w_m_rready;
    assign o_busy      = (r_state != IDLE);
    assign o_owner     = r_owner;
    assign o_len_err   = r_len_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter. It plays the slave and both requesters.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr;
    logic [7:0]  p0_len, p1_len;
    logic        p0_gnt, p1_gnt;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_rvalid, p1_rvalid, p0_rlast, p1_rlast;
    logic        p0_rready, p1_rready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_rlast, m_rready;
    logic        busy, owner, len_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_p0_req(p0_req), .i_p1_req(p1_req),
        .i_p0_addr(p0_addr), .i_p1_addr(p1_addr),
        .i_p0_len(p0_len), .i_p1_len(p1_len),
        .o_p0_gnt(p0_gnt), .o_p1_gnt(p1_gnt),
        .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
        .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
        .o_p0_rlast(p0_rlast), .o_p1_rlast(p1_rlast),
        .i_p0_rready(p0_rready), .i_p1_rready(p1_rready),
        .o_m_araddr(m_araddr), .o_m_arlen(m_arlen),
        .o_m_arvalid(m_arvalid), .i_m_arready(m_arready),
        .i_m_rdata(m_rdata), .i_m_rvalid(m_rvalid), .i_m_rlast(m_rlast),
        .o_m_rready(m_rready),
        .o_busy(busy), .o_owner(owner), .o_len_err(len_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // DUT is in IDLE with req(s) already raised; expects this port to win.
    task automatic start_burst(input logic port, input logic [31:0] addr,
                               input logic [7:0] len, input int ar_wait);
        tick; settle;
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, len);
        chk("owner", owner, port);
        chk("busy_addr", busy, 1);
        for (int w = 0; w < ar_wait; w++) begin
            tick; settle;
            chk("ar_hold_valid", m_arvalid, 1);
            chk("ar_hold_addr", m_araddr, addr);
            chk("ar_hold_len", m_arlen, len);
            chk("gnt_early", p0_gnt | p1_gnt, 0);
        end
        m_arready = 1'b1;
        tick;
        m_arready = 1'b0;
        settle;
        chk("gnt_own", port ? p1_gnt : p0_gnt, 1);
        chk("gnt_other", port ? p0_gnt : p1_gnt, 0);
        chk("ar_drop", m_arvalid, 0);
    endtask

    // Slave returns n beats with m_rlast on index rl_idx; owner rready held high.
    task automatic run_beats(input logic port, input int n, input int len, input int rl_idx);
        if (port) p1_rready = 1'b1; else p0_rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hD000_0000 | (32'(port) << 8) | 32'(i);
            m_rlast  = (i == rl_idx);
            settle;
            chk("rvalid_own", port ? p1_rvalid : p0_rvalid, 1);
            chk("rvalid_other", port ? p0_rvalid : p1_rvalid, 0);
            chk("rdata_own", port ? p1_rdata : p0_rdata, 32'hD000_0000 | (32'(port) << 8) | 32'(i));
            chk("rlast_own", port ? p1_rlast : p0_rlast, (i == len) ? 1 : 0);
            chk("m_rready", m_rready, 1);
            if (i == 1) chk("gnt_once", port ? p1_gnt : p0_gnt, 0);
            tick;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        settle;
        chk("busy_end", busy, 0);
        chk("rvalid_idle", p0_rvalid | p1_rvalid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p1_req = 0; p0_addr = 0; p1_addr = 0; p0_len = 0; p1_len = 0;
        p0_rready = 0; p1_rready = 0;
        m_arready = 0; m_rdata = 0; m_rvalid = 0; m_rlast = 0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_gnt", p0_gnt | p1_gnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_rready", m_rready, 0);
        rst_n = 1'b1;

        // Single port p0, addr 0x10, len 3.
        p0_req = 1; p0_addr = 32'h10; p0_len = 8'd3;
        settle;
        chk("idle_busy", busy, 0);
        start_burst(1'b0, 32'h10, 8'd3, 0);
        p0_req = 0;
        run_beats(1'b0, 4, 3, 3);
        chk("single_len_err", len_err, 0);

        // Both ports requesting right after reset: p0, p1, p0, p1.
        rst_n = 1'b0; tick; rst_n = 1'b1;
        p0_req = 1; p0_addr = 32'h100; p0_len = 0;
        p1_req = 1; p1_addr = 32'h200; p1_len = 0;
        for (int k = 0; k < 4; k++) begin
            start_burst(k[0], k[0] ? 32'h200 : 32'h100, 8'd0, 0);
            run_beats(k[0], 1, 0, 0);
        end
        p0_req = 0; p1_req = 0;

        // Backpressure on p1, len 7; rready toggles 1-0-1-0.
        p1_req = 1; p1_addr = 32'h300; p1_len = 8'd7;
        start_burst(1'b1, 32'h300, 8'd7, 0);
        p1_req = 0;
        begin
            int acc = 0;
            for (int c = 0; c < 15; c++) begin
                p1_rready = (c % 2 == 0);
                m_rvalid  = 1'b1;
                m_rdata   = 32'hB0 + 32'(acc);
                m_rlast   = (acc == 7);
                settle;
                chk("bp_rready", m_rready, p1_rready);
                chk("bp_rlast", p1_rlast, (acc == 7) ? 1 : 0);
                chk("bp_p0_rvalid", p0_rvalid, 0);
                chk("bp_busy", busy, 1);
                if (p1_rready) acc++;
                tick;
            end
            m_rvalid = 0; m_rlast = 0;
            settle;
            chk("bp_done", busy, 0);
        end

        // Slave holds off arready for 3 cycles.
        p0_req = 1; p0_addr = 32'h40; p0_len = 8'd1;
        start_burst(1'b0, 32'h40, 8'd1, 3);
        p0_req = 0;
        run_beats(1'b0, 2, 1, 1);

        // Early slave rlast on beat 2 of a len 3 burst.
        p0_req = 1; p0_addr = 32'h50; p0_len = 8'd3;
        start_burst(1'b0, 32'h50, 8'd3, 0);
        p0_req = 0;
        run_beats(1'b0, 2, 3, 1);
        chk("len_err_set", len_err, 1);
        p1_req = 1; p1_addr = 32'h58; p1_len = 8'd0;
        start_burst(1'b1, 32'h58, 8'd0, 0);
        p1_req = 0;
        run_beats(1'b1, 1, 0, 0);
        chk("len_err_sticky", len_err, 1);

        // Reset during beat 2 of a len 5 burst.
        p0_req = 1; p0_addr = 32'h70; p0_len = 8'd5;
        start_burst(1'b0, 32'h70, 8'd5, 0);
        p0_req = 0;
        p0_rready = 1; m_rvalid = 1; m_rdata = 32'h1; m_rlast = 0;
        tick;
        m_rdata = 32'h2;
        rst_n = 1'b0;
        tick;
        m_rvalid = 0;
        settle;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rready", m_rready, 0);
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_len_err", len_err, 0);
        rst_n = 1'b1;
        p1_req = 1; p1_addr = 32'h60; p1_len = 8'd0;
        start_burst(1'b1, 32'h60, 8'd0, 0);
        p1_req = 0;
        run_beats(1'b1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1);
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-port round-robin arbiter that shares a single AXI read channel (AR + R) of the word-addressed memory slave between two requesters, e.g. two image-block processing engines. It accepts one burst request per port, issues it on the AR channel, steers the returning R beats to the owning port, and enforces one outstanding burst at a time. It sits between the processing engines and the memory slave's read ports; the write channels are not touched.

## Interface
- ADDR_WIDTH, 32, word address width (one address = one DATA_WIDTH word)
- DATA_WIDTH, 32, read data width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- p0_req, p1_req  in  1  burst request; held high with stable addr/len until matching gnt
- p0_addr, p1_addr  in  ADDR_WIDTH  burst start word address
- p0_len, p1_len  in  8  AXI-style length: beats minus 1
- p0_gnt, p1_gnt  out  1  one-cycle pulse when that port's AR handshake completes
- p0_rdata, p1_rdata  out  DATA_WIDTH  read data, both driven from m_rdata
- p0_rvalid, p1_rvalid  out  1  m_rvalid gated to the owning port only
- p0_rlast, p1_rlast  out  1  end-of-burst beat marker for the owning port
- p0_rready, p1_rready  in  1  port read-ready
- m_araddr  out  ADDR_WIDTH  to slave araddr
- m_arlen  out  8  to slave arlen
- m_arvalid  out  1  to slave arvalid
- m_arready  in  1  from slave arready
- m_rdata  in  DATA_WIDTH  from slave rdata
- m_rvalid, m_rlast  in  1  from slave
- m_rready  out  1  to slave rready
- busy  out  1  high in ADDR or DATA state
- owner  out  1  port currently owning the channel (valid while busy)
- len_err  out  1  sticky: slave rlast disagreed with beat count; cleared only by reset

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if exactly one req high, select it; if both, select the port not granted last (last_gnt pointer). Latch addr, len, owner into registers; set m_arvalid; go ADDR. No req: stay.
- ADDR: m_araddr/m_arlen/m_arvalid held stable from registers. On m_arvalid && m_arready: clear m_arvalid, pulse owner's gnt, clear beat_cnt, go DATA.
- DATA: m_rready = owner's rready; owner's rvalid = m_rvalid; other port's rvalid = 0. Each m_rvalid && m_rready increments beat_cnt (8 bits, + 1 wrap bit not needed: max 256 beats).
- Port rlast = owner selected && m_rvalid && (beat_cnt == len); generated locally, not forwarded from slave.
- Burst end: accepted beat with beat_cnt == len, OR accepted beat with m_rlast, whichever occurs first. On end: last_gnt <= owner; go IDLE.
- len_err set if the ending beat has m_rlast != (beat_cnt == len).
- Non-owner port's requests remain pending; requesters never see rvalid outside their own burst.
- Outside DATA: m_rready = 0, both port rvalid = 0.

## Timing
- Reset values: m_arvalid 0, m_araddr 0, m_arlen 0, gnt 0, busy 0, owner 0, len_err 0, last_gnt 1 (port 0 wins first tie), state IDLE.
- req sampled in IDLE at edge N -> m_arvalid high from cycle N+1.
- gnt pulses in the cycle after the AR handshake edge, coincident with entry to DATA.
- R path combinational (rdata, rvalid, rready, rlast): zero added latency per beat.
- Burst end edge -> IDLE next cycle; next burst's m_arvalid no earlier than 2 cycles after the final beat (one IDLE cycle mandatory).
- m_arvalid never drops before m_arready; addr/len never change while m_arvalid high.
- Request deasserted in IDLE before selection: ignored. Request dropped after selection: burst still completes (spec violation by requester, not checked).
- rst_n low mid-burst: return to IDLE next edge, all outputs to reset values; in-flight slave beats are not drained.

## Test plan
- Single port: p0 req addr 0x10, len 3 -> one AR (araddr 0x10, arlen 3), p0_gnt one pulse, 4 beats on p0 with p0_rlast on 4th, p1_rvalid stays 0, busy drops after 4th beat.
- Simultaneous p0/p1 req after reset -> p0 served first, then p1; with both held continuously, grants alternate p0, p1, p0, p1.
- Backpressure: p1 len 7, p1_rready toggled 1-0-1-0 -> m_rready mirrors it, exactly 8 beats accepted, beat_cnt not advanced on stalled cycles.
- Slave arready delayed 3 cycles -> m_arvalid/araddr/arlen stable all 4 cycles, gnt pulses once.
- len mismatch: len 3 but slave asserts m_rlast on beat 2 -> burst ends after beat 2, len_err set and stays set through later good bursts.
- Reset asserted during beat 2 of a len 5 burst -> next cycle busy 0, m_rready 0, m_arvalid 0, len_err 0; new p1 req then served normally.
